bus_arbiter_n: RTL

- Parametrised successor to the CPU's single-port wishbone bus bridge.
- Arbitrates NCH independent request channels (channel 0 = instruction fetch, channel 1 = data memory, channels 2+ = TLB refill / DMA) onto one Wishbone classic master port.
- Provides per-channel stall requests to ctrl, flush-safe transaction abort, selectable fixed or round-robin priority, and a bus watchdog.
- Sits between pc_reg/mem/tlb and the top-level wishbone pins.

---
 rtl/bus_arbiter_n.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter_n.sv
// N-channel Wishbone classic bus arbiter.
// Grants one of NCH request channels onto a single Wishbone master port,
// using either fixed (highest index wins) or round-robin priority.
// A flushed channel's in-flight cycle is drained, never aborted, so the
// slave always sees a complete handshake. A watchdog ends cycles the
// slave never acknowledges and reports them to the owning channel as an
// error completion.
module bus_arbiter_n #(
  parameter int NCH       = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int SELW      = DW / 8,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       ch_req_i,
  input  logic [NCH-1:0]       ch_we_i,
  input  logic [NCH*AW-1:0]    ch_addr_i,
  input  logic [NCH*DW-1:0]    ch_data_i,
  input  logic [NCH*SELW-1:0]  ch_sel_i,
  input  logic [NCH-1:0]       ch_flush_i,
  output logic [NCH*DW-1:0]    ch_data_o,
  output logic [NCH-1:0]       ch_done_o,
  output logic [NCH-1:0]       ch_err_o,
  output logic [NCH-1:0]       ch_stall_req_o,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [AW-1:0]        wb_addr_o,
  output logic [DW-1:0]        wb_data_o,
  output logic [SELW-1:0]      wb_sel_o,
  input  logic [DW-1:0]        wb_data_i,
  input  logic                 wb_ack_i
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN
  } state_t;

  state_t          state;
  logic [IW-1:0]   grant_q;
  logic [IW-1:0]   rr_ptr;
  logic [CW-1:0]   wd_cnt;

  logic [NCH-1:0]  eligible;
  logic            grant_valid;
  logic [IW-1:0]   grant_idx;
  logic [IW-1:0]   cand;
  logic            wd_hit;
  logic            cycle_end;
  logic [IW-1:0]   next_ptr;

  // A channel stalls while it wants the bus and has not yet seen its done
  // pulse; the same vector decides who may be granted, so a channel still
  // holding its request during its own done cycle is not granted again.
  assign ch_stall_req_o = ch_req_i & ~ch_flush_i & ~ch_done_o;
  assign eligible       = ch_stall_req_o;

  // Watchdog expires on the TIMEOUT-th cycle spent in BUSY/DRAIN.
  assign wd_hit    = (TIMEOUT != 0) && (int'(wd_cnt) == TIMEOUT - 1);
  assign cycle_end = (state != IDLE) && (wb_ack_i || wd_hit);
  assign next_ptr  = (grant_q == IW'(NCH - 1)) ? '0 : grant_q + IW'(1);

  // Grant selection: fixed priority or first eligible at/after the pointer.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    if (PRIO_MODE == 0) begin
      // Ascending scan: the last hit, i.e. the highest index, wins.
      for (int i = 0; i < NCH; i++) begin
        cand = IW'(i);
        if (eligible[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = cand;
        end
      end
    end else begin
      // Descending offset scan: the last hit is the nearest to the pointer.
      for (int off = NCH - 1; off >= 0; off--) begin
        cand = IW'((int'(rr_ptr) + off) % NCH);
        if (eligible[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  // Bus FSM with registered Wishbone outputs and per-channel completions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: all state, including the per-channel read-data registers, is
      // reset so nothing visible on the ports is ever undefined.
      state     <= IDLE;
      grant_q   <= '0;
      rr_ptr    <= '0;
      wd_cnt    <= '0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_addr_o <= '0;
      wb_data_o <= '0;
      wb_sel_o  <= '0;
      ch_data_o <= '0;
      ch_done_o <= '0;
      ch_err_o  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every read below sees
      // the pre-edge value regardless of statement order.
      ch_done_o <= '0;
      ch_err_o  <= '0;
      if (state == IDLE) begin
        wd_cnt <= '0;
        if (grant_valid) begin
          state     <= BUSY;
          grant_q   <= grant_idx;
          wb_cyc_o  <= 1'b1;
          wb_stb_o  <= 1'b1;
          wb_we_o   <= ch_we_i[grant_idx];
          wb_addr_o <= ch_addr_i[grant_idx*AW +: AW];
          wb_data_o <= ch_data_i[grant_idx*DW +: DW];
          wb_sel_o  <= ch_sel_i[grant_idx*SELW +: SELW];
        end
      end else if (cycle_end) begin
        // Ack or watchdog: the Wishbone cycle ends here in either state.
        state    <= IDLE;
        wb_cyc_o <= 1'b0;
        wb_stb_o <= 1'b0;
        wd_cnt   <= '0;
        rr_ptr   <= next_ptr;
        // Only a channel that still owns its request gets a completion;
        // a drained or same-cycle-flushed transfer is silently discarded.
        if (state == BUSY && !ch_flush_i[grant_q]) begin
          ch_done_o[grant_q] <= 1'b1;
          if (wb_ack_i) begin
            if (!wb_we_o) begin
              ch_data_o[grant_q*DW +: DW] <= wb_data_i;
            end
          end else begin
            ch_err_o[grant_q]           <= 1'b1;
            ch_data_o[grant_q*DW +: DW] <= '0;
          end
        end
      end else begin
        // Cycle still open: keep cyc/stb up, and move to DRAIN if the owner
        // walks away so the slave's eventual ack is absorbed here.
        wd_cnt <= wd_cnt + CW'(1);
        if (ch_flush_i[grant_q]) begin
          state <= DRAIN;
        end
      end
    end
  end

endmodule
